// File: rtl/arith_seq_ctrl_if.sv
// rtl/arith_seq_ctrl_if.sv - stimulus/scoreboard bus between sequencer and test environment
interface arith_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             i_start;
  logic [CNT_W-1:0] i_num;
  logic             i_stall;
  logic [WIDTH-1:0] o_a;
  logic [WIDTH-1:0] o_b;
  logic             o_valid;
  logic [WIDTH-1:0] i_mon_o;
  logic [WIDTH-1:0] i_dtm_o;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_first_idx;
  logic [WIDTH-1:0] o_first_mon;
  logic [WIDTH-1:0] o_first_dtm;

  modport master (
    input  i_start, i_num, i_stall, i_mon_o, i_dtm_o,
    output o_a, o_b, o_valid, o_busy, o_done, o_err_cnt, o_first_idx, o_first_mon, o_first_dtm
  );

  modport slave (
    output i_start, i_num, i_stall, i_mon_o, i_dtm_o,
    input  o_a, o_b, o_valid, o_busy, o_done, o_err_cnt, o_first_idx, o_first_mon, o_first_dtm
  );
endinterface

// File: rtl/arith_seq_ctrl.sv
// rtl/arith_seq_ctrl.sv - LFSR operand sequencer with latency-aligned result scoreboard
module arith_seq_ctrl #(
  parameter int          WIDTH   = 32,
  parameter int          CNT_W   = 16,
  parameter int          CMP_LAT = 2,
  parameter logic [31:0] SEED_A  = 32'h0000_0001,
  parameter logic [31:0] SEED_B  = 32'h1234_5679
) (
  input  logic            clk,
  input  logic            reset,
  arith_seq_ctrl_if.master bus
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [31:0] SA      = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [31:0] SB      = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
  localparam logic [31:0] POLY    = 32'hB4BC_D35C;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   issued;
  logic [31:0]        lfsr_a;
  logic [31:0]        lfsr_b;
  logic [CMP_LAT-1:0] pipe_v;
  logic [CNT_W-1:0]   pipe_idx [CMP_LAT];
  logic               first_seen;
  logic               issue;
  logic               mismatch;
  logic               pend;

  // pend: entries still in flight once this edge's compare retires the last stage
  always_comb begin
    issue    = (state == S_RUN) && !bus.i_stall && (issued < num_q);
    mismatch = pipe_v[CMP_LAT-1] && (bus.i_mon_o != bus.i_dtm_o);
    pend     = 1'b0;
    for (int i = 0; i < CMP_LAT - 1; i++) pend = pend | pipe_v[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      num_q           <= '0;
      issued          <= '0;
      lfsr_a          <= SA;
      lfsr_b          <= SB;
      pipe_v          <= '0;
      for (int i = 0; i < CMP_LAT; i++) pipe_idx[i] <= '0;
      first_seen      <= 1'b0;
      bus.o_a         <= '0;
      bus.o_b         <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_err_cnt   <= '0;
      bus.o_first_idx <= '0;
      bus.o_first_mon <= '0;
      bus.o_first_dtm <= '0;
    end else begin
      bus.o_done  <= 1'b0;
      pipe_v[0]   <= issue;
      pipe_idx[0] <= issued;
      for (int i = 1; i < CMP_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end

      if (mismatch) begin
        if (bus.o_err_cnt != '1) bus.o_err_cnt <= bus.o_err_cnt + 1'b1;
        if (!first_seen) begin
          first_seen      <= 1'b1;
          bus.o_first_idx <= pipe_idx[CMP_LAT-1];
          bus.o_first_mon <= bus.i_mon_o;
          bus.o_first_dtm <= bus.i_dtm_o;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state           <= S_RUN;
            num_q           <= bus.i_num;
            issued          <= '0;
            lfsr_a          <= SA;
            lfsr_b          <= SB;
            first_seen      <= 1'b0;
            bus.o_busy      <= 1'b1;
            bus.o_err_cnt   <= '0;
            bus.o_first_idx <= '0;
            bus.o_first_mon <= '0;
            bus.o_first_dtm <= '0;
          end
        end
        S_RUN: begin
          bus.o_valid <= issue;
          if (issue) begin
            bus.o_a <= lfsr_a[WIDTH-1:0];
            bus.o_b <= lfsr_b[WIDTH-1:0];
            lfsr_a  <= lfsr_next(lfsr_a);
            lfsr_b  <= lfsr_next(lfsr_b);
            issued  <= issued + 1'b1;
          end
          if ((issued >= num_q) || (issue && (issued == num_q - 1'b1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          bus.o_valid <= 1'b0;
          if (!pend) begin
            state      <= S_DONE;
            bus.o_done <= 1'b1;
            bus.o_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arith_seq_ctrl.sv
// tb/tb_arith_seq_ctrl.sv - directed table-driven bench for arith_seq_ctrl
module tb_arith_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arith_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  arith_seq_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .CMP_LAT(2),
    .SEED_A(32'h0000_0001), .SEED_B(32'h1234_5679)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int num;
    int err_vec;
    bit inv;
    int stall_len;
    bit mid_start;
    int exp_valids;
    int exp_err;
    int exp_first;
    int exp_done;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ma [16];
  logic [31:0] mb [16];
  logic [31:0] hand_a [4];
  vec_t        tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'hB4BC_D35C) : (s >> 1);
  endfunction

  task automatic run_vec(input vec_t v, input int row);
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] pval, em, ed;
    int          e, nvalid, done_edge, pidx, stall_left, bad;
    bit          pv;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_num   = v.num[CNT_W-1:0];
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check($sformatf("r%0d_busy_after_start", row), bus.o_busy, 1);
    e = 0; nvalid = 0; done_edge = -1; pv = 0; pidx = 0; pval = 0; stall_left = 0;
    while (done_edge < 0 && e < 60) begin
      @(posedge clk); #1;
      e++;
      if (pv) begin
        bus.i_mon_o = pval;
        bus.i_dtm_o = v.inv ? ~pval : ((pidx == v.err_vec) ? (pval ^ 32'd1) : pval);
      end else begin
        bus.i_mon_o = $urandom;
        bus.i_dtm_o = v.inv ? ~bus.i_mon_o : bus.i_mon_o;
      end
      pv   = bus.o_valid;
      pval = bus.o_a + bus.o_b;
      pidx = nvalid;
      if (bus.o_valid) begin
        qa.push_back(bus.o_a);
        qb.push_back(bus.o_b);
        nvalid++;
        if (nvalid == 2 && v.stall_len > 0) stall_left = v.stall_len;
      end
      bus.i_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (v.mid_start && e == 3) begin
        bus.i_start = 1'b1;
        bus.i_num   = 4'd2;
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_done) done_edge = e;
    end
    bus.i_stall = 1'b0;
    check($sformatf("r%0d_done_edge", row), done_edge, v.exp_done);
    check($sformatf("r%0d_busy_at_done", row), bus.o_busy, 0);
    @(posedge clk); #1;
    check($sformatf("r%0d_done_one_cycle", row), bus.o_done, 0);
    check($sformatf("r%0d_valid_count", row), qa.size(), v.exp_valids);
    check($sformatf("r%0d_err_cnt", row), bus.o_err_cnt, v.exp_err);
    check($sformatf("r%0d_first_idx", row), bus.o_first_idx, v.exp_first);
    em = 0; ed = 0;
    if (v.exp_err > 0) begin
      em = ma[v.exp_first] + mb[v.exp_first];
      ed = v.inv ? ~em : (em ^ 32'd1);
    end
    check($sformatf("r%0d_first_mon", row), bus.o_first_mon, em);
    check($sformatf("r%0d_first_dtm", row), bus.o_first_dtm, ed);
    bad = 0;
    for (int k = 0; k < qa.size(); k++)
      if (k >= 16 || qa[k] !== ma[k] || qb[k] !== mb[k]) bad++;
    check($sformatf("r%0d_operand_seq_errors", row), bad, 0);
    if (row == 0 && qa.size() >= 4)
      for (int k = 0; k < 4; k++) check($sformatf("r0_hand_a%0d", k), qa[k], hand_a[k]);
  endtask

  initial begin
    int nv;
    bus.i_start = 1'b0;
    bus.i_num   = '0;
    bus.i_stall = 1'b0;
    bus.i_mon_o = '0;
    bus.i_dtm_o = '0;

    ma[0] = 32'h0000_0001;
    mb[0] = 32'h1234_5679;
    for (int k = 1; k < 16; k++) begin
      ma[k] = step(ma[k-1]);
      mb[k] = step(mb[k-1]);
    end
    hand_a[0] = 32'h0000_0001;
    hand_a[1] = 32'hB4BC_D35C;
    hand_a[2] = 32'h5A5E_69AE;
    hand_a[3] = 32'h2D2F_34D7;

    //            num err inv stl mid  vld err first done
    tbl[0] = '{8,  -1, 0, 0, 0, 8,  0,  0, 10};
    tbl[1] = '{8,   3, 0, 0, 0, 8,  1,  3, 10};
    tbl[2] = '{4,  -1, 0, 3, 0, 4,  0,  0,  9};
    tbl[3] = '{4,  -1, 0, 0, 0, 4,  0,  0,  6};
    tbl[4] = '{0,  -1, 0, 0, 0, 0,  0,  0,  2};
    tbl[5] = '{6,  -1, 0, 0, 1, 6,  0,  0,  8};
    tbl[6] = '{15, -1, 1, 0, 0, 15, 15, 0, 17};
    tbl[7] = '{15, -1, 1, 0, 0, 15, 15, 0, 17};

    #1;
    check("reset_a", bus.o_a, 0);
    check("reset_ctl", {bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_cnt, bus.o_first_idx}, 0);
    check("reset_first", {bus.o_first_mon, bus.o_first_dtm}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int r = 0; r < 8; r++) run_vec(tbl[r], r);

    // reset in the middle of a 10-vector run, then rerun from the seeds
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_num   = 4'd10;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    nv = 0;
    for (int i = 0; i < 20 && nv < 2; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid) begin
        check($sformatf("rst_run_a%0d", nv), bus.o_a, ma[nv]);
        nv++;
      end
    end
    check("rst_run_two_issues", nv, 2);
    reset = 1'b0;
    #1;
    check("midrst_a", bus.o_a, 0);
    check("midrst_b", bus.o_b, 0);
    check("midrst_ctl", {bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_cnt, bus.o_first_idx}, 0);
    check("midrst_first", {bus.o_first_mon, bus.o_first_dtm}, 0);
    @(posedge clk); #1;
    check("midrst_held", {bus.o_valid, bus.o_busy, bus.o_done}, 0);
    reset = 1'b1;
    run_vec('{10, -1, 0, 0, 0, 10, 0, 0, 12}, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_seq_ctrl.md
# arith_seq_ctrl

Stimulus sequencer and scoreboard controller for the arithmetic testbench. On a start pulse it issues a programmed number of pseudo-random operand pairs to the DUT and the monitor. It compares the monitor output against the DUT output after a fixed alignment latency. It reports the mismatch count, the first failing vector, and a done pulse.

## Interface
- WIDTH, 32, operand/result width (1..32)
- CNT_W, 16, vector count and error counter width
- CMP_LAT, 2, edges from operand issue to the edge that samples i_mon_o/i_dtm_o (≥1)
- SEED_A, 32'h0000_0001, LFSR A seed (0 replaced by 1)
- SEED_B, 32'h1234_5679, LFSR B seed (0 replaced by 1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- i_start  in  1  start request, honoured only in IDLE
- i_num  in  CNT_W  vectors per run, sampled with i_start
- i_stall  in  1  suppresses issue while high
- o_a, o_b  out  WIDTH  operands to DUT and monitor
- o_valid  out  1  operands issued this cycle
- i_mon_o  in  WIDTH  monitor reference result
- i_dtm_o  in  WIDTH  registered DUT result
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle completion pulse
- o_err_cnt  out  CNT_W  mismatch count, saturating
- o_first_idx  out  CNT_W  index (0-based) of first mismatch
- o_first_mon, o_first_dtm  out  WIDTH  values captured at first mismatch

## Operation
- **Reset values:** state IDLE; all outputs 0; LFSRs hold their seeds; alignment pipe cleared.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN:** on i_start. The start edge:
  - latches i_num;
  - clears the issued counter, o_err_cnt, the first-error flag and the captured registers;
  - reloads both LFSRs from their seeds.
  - Runs are therefore reproducible.
- **RUN, each edge with i_stall low and issued < num:**
  - o_a ← lfsr_a[WIDTH-1:0], o_b ← lfsr_b[WIDTH-1:0], o_valid ← 1;
  - both LFSRs advance;
  - issued increments;
  - the edge that issues vector num-1 moves to DRAIN.
- **RUN with i_stall high:** o_valid ← 0, o_a/o_b hold, LFSRs hold, pipe keeps shifting.
- **RUN with num = 0:** moves to DRAIN on the first RUN edge, no issue.
- **LFSR:** 32-bit Galois, right shift. If bit0 = 1: s ← (s>>1) ^ 32'hB4BC_D35C, else s ← s>>1.
- **Alignment pipe:** CMP_LAT stages carrying valid and index. A vector issued at edge E is compared at edge E+CMP_LAT.
- **Compare edge:**
  - mismatch when i_mon_o ≠ i_dtm_o;
  - o_err_cnt increments, saturating at 2^CNT_W−1;
  - the first mismatch of the run loads o_first_idx, o_first_mon and o_first_dtm; later mismatches do not change them.
- **DRAIN → DONE:** on the edge where no valid entry remains in the pipe after that edge's compare.
- **DONE:** o_done = 1 for exactly one cycle, then IDLE. Results hold until the next start.
- **i_start outside IDLE:** ignored; results are not disturbed.
- **Reset mid-run:** immediate return to reset values. In-flight compares are discarded.

## Timing
- Start sampled at edge E0. First o_valid is high after E1.
- With no stalls, vector k is issued at E(k+1) and compared at E(k+1+CMP_LAT).
- N ≥ 1, no stalls: DONE is entered at EN+CMP_LAT and o_done is high for the following cycle. Each stalled cycle adds one cycle.
- N = 0: DRAIN at E1, DONE at E2.
- o_busy is high from after E0 until DONE is entered. It is low while o_done is high.
- Every output is registered; no combinational path from an input to an output.

## Test plan
- **Loopback:** WIDTH=32, CMP_LAT=2, i_num=8, i_dtm_o tied to i_mon_o → 8 o_valid pulses, o_err_cnt=0, o_done high after E10.
- **Single injected error:** i_dtm_o = i_mon_o ^ 1 only on the compare edge of vector 3, i_num=8 → o_err_cnt=1, o_first_idx=3, o_first_dtm = o_first_mon ^ 1.
- **Stall:** i_num=4, i_stall high for 3 cycles after the second issue → exactly 4 issues, o_a sequence identical to the unstalled run, o_done 3 cycles later than unstalled.
- **Boundaries:** i_num=0 → no o_valid, o_done high after E2, o_err_cnt=0. i_start pulsed mid-run → ignored, counts unchanged.
- **Saturation:** CNT_W=4, i_num=15, i_dtm_o = ~i_mon_o → o_err_cnt=15, o_first_idx=0. Repeat the run with i_dtm_o held at ~i_mon_o → results cleared at start, o_err_cnt=15 again.
- **Reset:** reset low after 2 issues of a 10-vector run → all outputs 0 immediately. Rerun after release gives the same o_a/o_b sequence from SEED_A/SEED_B.
